// File: rtl/trng_source_if.sv
// TRNG request/response port between the SoC (master) and the entropy source (slave).
// WIDTH must match the TRNG_WIDTH of the source it connects to.
interface trng_source_if #(
    parameter int WIDTH = 4
);
    logic             trng_req;
    logic [WIDTH-1:0] trng_word;
    logic             trng_valid;

    modport master (output trng_req, input trng_word, input trng_valid);
    modport slave  (input trng_req, output trng_word, output trng_valid);
endinterface

// File: rtl/trng_source.sv
// Entropy source: synchronized noise sampling, von Neumann debiasing, word packing with a
// one-word buffer, repetition-count health alarm, and a level-request/one-pulse responder.
module trng_source #(
    parameter int TRNG_WIDTH = 4,
    parameter int SAMPLE_DIV = 2,
    parameter int REP_LIMIT  = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          noise_in,
    trng_source_if.slave  trng,
    output logic          health_fail
);
    localparam int CNT_W = $clog2(TRNG_WIDTH + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SERVE, ST_ACK, ST_HOLD} state_t;

    logic [1:0]            sync_q;
    logic [15:0]           div_q;
    logic                  phase_q;
    logic                  first_q;
    logic                  prev_q;
    logic [7:0]            rep_cnt_q;
    logic [7:0]            rep_cnt_d;
    logic                  health_fail_q;
    logic                  health_fail_d;
    logic [TRNG_WIDTH-1:0] acc_q;
    logic [TRNG_WIDTH-1:0] acc_d;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [CNT_W-1:0]      bit_cnt_d;
    logic [TRNG_WIDTH-1:0] buf_q;
    logic                  buf_full_q;
    state_t                state_q;
    logic [TRNG_WIDTH-1:0] word_q;
    logic                  valid_q;

    logic s;
    logic tick;
    logic vn_valid;
    logic emit;
    logic unload;
    logic load;

    assign s    = sync_q[1];
    assign tick = (div_q == 16'(SAMPLE_DIV - 1));

    // Second sample of a differing pair yields the first sample's value (10 -> 1, 01 -> 0).
    assign vn_valid = tick && phase_q && (first_q != s);
    assign emit     = vn_valid && !health_fail_q && (bit_cnt_q < CNT_W'(TRNG_WIDTH));

    genvar gi;
    generate
        for (gi = 0; gi < TRNG_WIDTH; gi++) begin : g_acc
            assign acc_d[gi] = (emit && (bit_cnt_q == CNT_W'(gi))) ? first_q : acc_q[gi];
        end
    endgenerate

    assign bit_cnt_d = emit ? (bit_cnt_q + CNT_W'(1)) : bit_cnt_q;
    assign unload    = (state_q == ST_SERVE) && trng.trng_req && buf_full_q && !health_fail_q;
    // An unload frees the buffer in the same cycle, so a completing word can slip straight in.
    assign load      = !health_fail_q && (bit_cnt_d == CNT_W'(TRNG_WIDTH))
                       && (!buf_full_q || unload);

    assign rep_cnt_d     = (s != prev_q)       ? 8'd1 :
                           (rep_cnt_q == 8'hFF) ? 8'hFF : (rep_cnt_q + 8'd1);
    assign health_fail_d = health_fail_q || (tick && (rep_cnt_d >= 8'(REP_LIMIT)));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q        <= '0;
            div_q         <= '0;
            phase_q       <= 1'b0;
            first_q       <= 1'b0;
            prev_q        <= 1'b0;
            rep_cnt_q     <= '0;
            health_fail_q <= 1'b0;
            acc_q         <= '0;
            bit_cnt_q     <= '0;
            buf_q         <= '0;
            buf_full_q    <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], noise_in};
            div_q         <= tick ? 16'd0 : (div_q + 16'd1);
            health_fail_q <= health_fail_d;
            if (tick) begin
                phase_q   <= ~phase_q;
                first_q   <= phase_q ? first_q : s;
                prev_q    <= s;
                rep_cnt_q <= rep_cnt_d;
            end
            if (health_fail_q) begin
                buf_full_q <= 1'b0;
            end else begin
                acc_q     <= acc_d;
                bit_cnt_q <= load ? '0 : bit_cnt_d;
                if (load) begin
                    buf_q      <= acc_d;
                    buf_full_q <= 1'b1;
                end else if (unload) begin
                    buf_full_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trng.trng_req) state_q <= ST_SERVE;
                end
                ST_SERVE: begin
                    if (!trng.trng_req) begin
                        state_q <= ST_IDLE;
                    end else if (buf_full_q && !health_fail_q) begin
                        state_q <= ST_ACK;
                        word_q  <= buf_q;
                        valid_q <= 1'b1;
                    end
                end
                ST_ACK: begin
                    valid_q <= 1'b0;
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!trng.trng_req) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign trng.trng_word  = word_q;
    assign trng.trng_valid = valid_q;
    assign health_fail     = health_fail_q;
endmodule

// File: tb/tb_trng_source.sv
// Directed bench for trng_source: noise samples are scripted per tick, words are requested
// through the interface and checked against hand-derived von Neumann results.
module tb_trng_source;
    logic clk;
    logic resetn;
    logic noise_in;
    logic health_fail;
    int   tests;
    int   fails;
    int   cyc;
    logic pat_q[$];
    logic stuck;

    trng_source_if #(.WIDTH(4)) tif ();

    trng_source #(.TRNG_WIDTH(4), .SAMPLE_DIV(2), .REP_LIMIT(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .noise_in    (noise_in),
        .trng        (tif.slave),
        .health_fail (health_fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // After release, tick 1 sees the synchronizer reset value and tick 2 a zero pad, so
    // scripted sample j is the noise level at posedge 2j+4 and pairs stay aligned.
    // Past the script: repeating 0,0,1,1 (no emitted bits) or a stuck 1.
    function automatic logic noise_for(int e);
        int j;
        if (!resetn || e < 4) return 1'b0;
        j = (e - 4) >> 1;
        if (j < pat_q.size()) return pat_q[j];
        if (stuck) return 1'b1;
        return 1'(((j - pat_q.size()) >> 1) & 1);
    endfunction

    initial begin
        noise_in = 1'b0;
        forever begin
            @(negedge clk);
            noise_in = noise_for(cyc + 1);
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic request(input int hold, output int pulses, output logic [3:0] w, output int lat);
        pulses = 0;
        w      = 4'h0;
        lat    = -1;
        @(negedge clk);
        tif.trng_req = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (tif.trng_valid) begin
                pulses++;
                w = tif.trng_word;
                if (lat < 0) lat = i;
            end
        end
        tif.trng_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (tif.trng_valid) pulses++;
        end
    endtask

    task automatic test_reset();
        pat_q.delete();
        stuck = 1'b0;
        reset_dut();
        tests++;
        if (tif.trng_word !== 4'h0) begin
            fails++; $display("FAIL reset_word: got %h want 0", tif.trng_word);
        end
        tests++;
        if (tif.trng_valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid: got %b want 0", tif.trng_valid);
        end
        tests++;
        if (health_fail !== 1'b0) begin
            fails++; $display("FAIL reset_health: got %b want 0", health_fail);
        end
        $display("[TB] reset: word=%h valid=%b health=%b", tif.trng_word, tif.trng_valid, health_fail);
    endtask

    task automatic test_delivery();
        int p; int lat; logic [3:0] w;
        pat_q = '{1, 0, 0, 1, 1, 0, 0, 1};
        reset_dut();
        wait_cyc(24);
        request(10, p, w, lat);
        tests++;
        if (p !== 1) begin fails++; $display("FAIL delivery_pulses: got %0d want 1", p); end
        tests++;
        if (w !== 4'b0101) begin fails++; $display("FAIL delivery_word: got %b want 0101", w); end
        tests++;
        if (lat !== 2) begin fails++; $display("FAIL delivery_latency: got %0d want 2", lat); end
        tests++;
        if (tif.trng_word !== 4'b0101) begin
            fails++; $display("FAIL delivery_hold: got %b want 0101", tif.trng_word);
        end
        $display("[TB] delivery: pulses=%0d word=%b latency=%0d", p, w, lat);
    endtask

    task automatic test_discard();
        int p; int lat; logic [3:0] w;
        pat_q = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1};
        reset_dut();
        wait_cyc(32);
        request(10, p, w, lat);
        tests++;
        if (p !== 1) begin fails++; $display("FAIL discard_pulses: got %0d want 1", p); end
        tests++;
        if (w !== 4'b0101) begin fails++; $display("FAIL discard_word: got %b want 0101", w); end
        $display("[TB] discard: pulses=%0d word=%b", p, w);
    endtask

    task automatic test_handshake();
        int p; int lat; logic [3:0] w;
        pat_q = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1};
        reset_dut();
        wait_cyc(40);
        request(50, p, w, lat);
        tests++;
        if (p !== 1) begin fails++; $display("FAIL hold_pulses: got %0d want 1", p); end
        tests++;
        if (w !== 4'b0101) begin fails++; $display("FAIL hold_word: got %b want 0101", w); end
        $display("[TB] handshake hold: pulses=%0d word=%b", p, w);
        request(10, p, w, lat);
        tests++;
        if (p !== 1) begin fails++; $display("FAIL rereq_pulses: got %0d want 1", p); end
        tests++;
        if (w !== 4'b0011) begin fails++; $display("FAIL rereq_word: got %b want 0011", w); end
        $display("[TB] handshake rereq: pulses=%0d word=%b", p, w);
        pat_q.delete();
        reset_dut();
        request(3, p, w, lat);
        tests++;
        if (p !== 0) begin fails++; $display("FAIL cancel_pulses: got %0d want 0", p); end
        tests++;
        if (int'(dut.state_q) !== 0) begin
            fails++; $display("FAIL cancel_state: got %0d want 0", int'(dut.state_q));
        end
        $display("[TB] handshake cancel: pulses=%0d state=%0d", p, int'(dut.state_q));
    endtask

    task automatic test_back_to_back();
        int p; int lat; logic [3:0] w;
        pat_q = '{1, 0, 0, 1, 1, 0, 0, 1,
                  1, 0, 1, 0, 1, 0, 1, 0,
                  0, 1, 0, 1, 0, 1, 0, 1};
        reset_dut();
        wait_cyc(60);
        request(10, p, w, lat);
        tests++;
        if (p !== 1 || w !== 4'b0101) begin
            fails++; $display("FAIL bp_first: got %0d/%b want 1/0101", p, w);
        end
        $display("[TB] backpressure first: pulses=%0d word=%b", p, w);
        request(10, p, w, lat);
        tests++;
        if (p !== 1 || w !== 4'b1111) begin
            fails++; $display("FAIL bp_second: got %0d/%b want 1/1111", p, w);
        end
        $display("[TB] backpressure second: pulses=%0d word=%b", p, w);
        request(20, p, w, lat);
        tests++;
        if (p !== 0) begin fails++; $display("FAIL bp_dropped: got %0d want 0", p); end
        $display("[TB] backpressure third: pulses=%0d", p);
    endtask

    task automatic test_health();
        int p; int lat; logic [3:0] w;
        pat_q = '{1, 0, 0, 1, 1, 0, 0, 1};
        stuck = 1'b1;
        reset_dut();
        wait_cyc(81);
        tests++;
        if (health_fail !== 1'b0) begin fails++; $display("FAIL health_early: got %b want 0", health_fail); end
        @(negedge clk);
        tests++;
        if (health_fail !== 1'b1) begin fails++; $display("FAIL health_trip: got %b want 1", health_fail); end
        $display("[TB] health trip: cyc=%0d health=%b", cyc, health_fail);
        request(10, p, w, lat);
        tests++;
        if (p !== 0) begin fails++; $display("FAIL health_block: got %0d want 0", p); end
        repeat (100) @(negedge clk);
        tests++;
        if (health_fail !== 1'b1) begin fails++; $display("FAIL health_sticky: got %b want 1", health_fail); end
        $display("[TB] health blocked: pulses=%0d health=%b", p, health_fail);
        stuck = 1'b0;
        pat_q.delete();
        reset_dut();
        tests++;
        if (health_fail !== 1'b0) begin fails++; $display("FAIL health_clear: got %b want 0", health_fail); end
        $display("[TB] health after reset: health=%b", health_fail);
    endtask

    task automatic test_async_reset();
        logic seen;
        int   p;
        pat_q = '{1, 0, 0, 1, 1, 0, 0, 1};
        reset_dut();
        wait_cyc(24);
        tif.trng_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (tif.trng_valid) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++; $display("FAIL async_ack_timeout: got no valid want valid within 10 cycles");
        end else begin
            pat_q.delete();
            resetn = 1'b0;
            #1;
            tests++;
            if (tif.trng_valid !== 1'b0 || tif.trng_word !== 4'h0 || health_fail !== 1'b0) begin
                fails++; $display("FAIL async_outputs: got %b/%h/%b want 0/0/0",
                                  tif.trng_valid, tif.trng_word, health_fail);
            end
            tests++;
            if (dut.buf_full_q !== 1'b0) begin
                fails++; $display("FAIL async_buffer: got %b want 0", dut.buf_full_q);
            end
            $display("[TB] async reset: valid=%b word=%h buf_full=%b", tif.trng_valid, tif.trng_word, dut.buf_full_q);
        end
        @(negedge clk);
        resetn = 1'b1;
        p = 0;
        repeat (30) begin
            @(negedge clk);
            if (tif.trng_valid) p++;
        end
        tif.trng_req = 1'b0;
        tests++;
        if (p !== 0) begin fails++; $display("FAIL async_empty: got %0d want 0", p); end
        $display("[TB] async post-reset request: pulses=%0d", p);
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        resetn       = 1'b0;
        stuck        = 1'b0;
        tif.trng_req = 1'b0;
        test_reset();
        test_delivery();
        test_discard();
        test_handshake();
        test_back_to_back();
        test_health();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
